// File: rtl/bullet_fire_scheduler_pkg.sv
// Shared types and default constants for the bullet fire scheduler.
package bullet_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_ISSUE_E = 2'd2,
        S_ISSUE_P = 2'd3
    } sched_state_t;

    // 833_333 does not fit 16 bits, so the tick divider is 20 bits wide to keep 60 Hz at 50 MHz.
    localparam int unsigned TICK_DIV_DEF        = 833_333;
    localparam int unsigned PHASE_TICKS_DEF     = 128;
    localparam int unsigned N_ENEMY_DEF         = 15;
    localparam int unsigned PLAYER_COOLDOWN_DEF = 8;

    localparam int TICK_W      = 20;
    localparam int PHASE_CNT_W = 8;
    localparam int PHASE_W     = 2;
    localparam int IDX_W       = 4;
    localparam int CD_W        = 4;

endpackage

// File: rtl/bullet_fire_scheduler_tick_phase_gen.sv
// Game tick divider and phase counter: one-cycle tick strobe, phase-wrap strobe, 2-bit phase.
module tick_phase_gen
    import bullet_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
    parameter int unsigned PHASE_TICKS = PHASE_TICKS_DEF
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    output logic               o_fTick,
    output logic               o_fPhaseStart,
    output logic [PHASE_W-1:0] o_Phase
);

    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [PHASE_CNT_W-1:0] phase_tick_q, phase_tick_d;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic                   f_tick;
    logic                   f_phase_start;

    always_comb begin
        f_tick        = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        f_phase_start = f_tick && (phase_tick_q == PHASE_CNT_W'(PHASE_TICKS - 1));
        tick_cnt_d    = f_tick ? '0 : tick_cnt_q + TICK_W'(1);
        phase_tick_d  = phase_tick_q;
        phase_d       = phase_q;
        if (f_tick) begin
            phase_tick_d = f_phase_start ? '0 : phase_tick_q + PHASE_CNT_W'(1);
        end
        if (f_phase_start) begin
            phase_d = phase_q + PHASE_W'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            tick_cnt_q   <= '0;
            phase_tick_q <= '0;
            phase_q      <= '0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            phase_tick_q <= phase_tick_d;
            phase_q      <= phase_d;
        end
    end

    assign o_fTick       = f_tick;
    assign o_fPhaseStart = f_phase_start;
    assign o_Phase       = phase_q;

endmodule

// File: rtl/bullet_fire_scheduler.sv
// Merges per-phase enemy bullet spawns and rate-limited player shots into one
// valid/ready spawn command stream for the bullet slot datapath.
module bullet_fire_scheduler
    import bullet_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV        = TICK_DIV_DEF,
    parameter int unsigned PHASE_TICKS     = PHASE_TICKS_DEF,
    parameter int unsigned N_ENEMY         = N_ENEMY_DEF,
    parameter int unsigned PLAYER_COOLDOWN = PLAYER_COOLDOWN_DEF
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_fPlayerShoot,
    input  logic               i_PlayerAlive,
    input  logic [N_ENEMY-1:0] i_EnemyAlive,
    input  logic               i_SpawnReady,
    output logic               o_SpawnValid,
    output logic               o_SpawnIsPlayer,
    output logic [IDX_W-1:0]   o_SpawnEnemyIdx,
    output logic               o_fTick,
    output logic               o_fPhaseStart,
    output logic [PHASE_W-1:0] o_Phase,
    output logic               o_Busy
);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CD_W-1:0]  cooldown_q, cooldown_d;
    logic             pending_q, pending_d;
    logic             shoot_prev_q, shoot_prev_d;
    logic             scan_active_q, scan_active_d;
    logic             restart_q, restart_d;

    logic f_tick;
    logic f_phase_start;
    logic shoot_edge;
    logic spawn_valid;
    logic player_hs;
    logic last_idx;
    logic restart_hit;
    logic enemy_alive_at;

    tick_phase_gen #(
        .TICK_DIV    (TICK_DIV),
        .PHASE_TICKS (PHASE_TICKS)
    ) u_tick_phase_gen (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .o_fTick       (f_tick),
        .o_fPhaseStart (f_phase_start),
        .o_Phase       (o_Phase)
    );

    always_comb begin
        shoot_edge     = i_fPlayerShoot && !shoot_prev_q;
        spawn_valid    = (state_q == S_ISSUE_E) || (state_q == S_ISSUE_P);
        player_hs      = (state_q == S_ISSUE_P) && i_SpawnReady;
        last_idx       = (idx_q == IDX_W'(N_ENEMY - 1));
        // A phase wrap seen mid-handshake is remembered until the handshake completes.
        restart_hit    = f_phase_start || restart_q;
        enemy_alive_at = i_EnemyAlive[idx_q];

        state_d   = state_q;
        idx_d     = idx_q;
        restart_d = restart_q;

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d   = S_ISSUE_P;
                    restart_d = f_phase_start;
                end else if (f_phase_start) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (pending_q) begin
                    state_d = S_ISSUE_P;
                    if (f_phase_start) begin
                        idx_d = '0;
                    end
                end else if (f_phase_start) begin
                    idx_d = '0;
                end else if (enemy_alive_at) begin
                    state_d = S_ISSUE_E;
                end else if (last_idx) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_ISSUE_E: begin
                if (i_SpawnReady) begin
                    restart_d = 1'b0;
                    if (restart_hit) begin
                        state_d = S_SCAN;
                        idx_d   = '0;
                    end else if (last_idx) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SCAN;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else if (f_phase_start) begin
                    restart_d = 1'b1;
                end
            end
            S_ISSUE_P: begin
                if (i_SpawnReady) begin
                    restart_d = 1'b0;
                    if (restart_hit) begin
                        state_d = S_SCAN;
                        idx_d   = '0;
                    end else if (scan_active_q) begin
                        state_d = S_SCAN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (f_phase_start) begin
                    restart_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_IDLE:             scan_active_d = 1'b0;
            S_SCAN, S_ISSUE_E:  scan_active_d = 1'b1;
            default:            scan_active_d = scan_active_q;
        endcase

        // Once the player command is on the bus it is never withdrawn.
        pending_d = pending_q;
        if (player_hs) begin
            pending_d = 1'b0;
        end else if (!i_PlayerAlive && (state_q != S_ISSUE_P)) begin
            pending_d = 1'b0;
        end else if (shoot_edge && i_PlayerAlive && (cooldown_q == '0)) begin
            pending_d = 1'b1;
        end

        cooldown_d = cooldown_q;
        if (player_hs) begin
            cooldown_d = CD_W'(PLAYER_COOLDOWN);
        end else if (f_tick && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - CD_W'(1);
        end

        shoot_prev_d = i_fPlayerShoot;
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cooldown_q    <= '0;
            pending_q     <= 1'b0;
            shoot_prev_q  <= 1'b0;
            scan_active_q <= 1'b0;
            restart_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cooldown_q    <= cooldown_d;
            pending_q     <= pending_d;
            shoot_prev_q  <= shoot_prev_d;
            scan_active_q <= scan_active_d;
            restart_q     <= restart_d;
        end
    end

    assign o_SpawnValid    = spawn_valid;
    assign o_SpawnIsPlayer = (state_q == S_ISSUE_P);
    assign o_SpawnEnemyIdx = (state_q == S_ISSUE_E) ? idx_q : '0;
    assign o_fTick         = f_tick;
    assign o_fPhaseStart   = f_phase_start;
    assign o_Busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_bullet_fire_scheduler.sv
// Self-checking bench: tick/phase timing table plus scoreboarded spawn scenarios.
module tb_bullet_fire_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        shoot = 1'b0;
    logic        p_alive = 1'b1;
    logic [14:0] e_alive = '0;
    logic        ready = 1'b1;

    logic        valid, is_p, ftick, pstart, busy;
    logic [3:0]  idx;
    logic [1:0]  phase;

    logic        t_valid, t_is_p, t_ftick, t_pstart, t_busy;
    logic [3:0]  t_idx;
    logic [1:0]  t_phase;

    int checks = 0;
    int failures = 0;
    int hs_count = 0;

    typedef struct {
        logic       is_player;
        logic [3:0] idx;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int         c;
        logic       tick;
        logic       pstart;
        logic [1:0] phase;
    } tvec_t;
    tvec_t tv[14];

    always #5 clk = ~clk;

    bullet_fire_scheduler #(
        .TICK_DIV(4), .PHASE_TICKS(16), .N_ENEMY(15), .PLAYER_COOLDOWN(2)
    ) dut (
        .i_Clk(clk), .i_Rst(rst_n), .i_fPlayerShoot(shoot), .i_PlayerAlive(p_alive),
        .i_EnemyAlive(e_alive), .i_SpawnReady(ready), .o_SpawnValid(valid),
        .o_SpawnIsPlayer(is_p), .o_SpawnEnemyIdx(idx), .o_fTick(ftick),
        .o_fPhaseStart(pstart), .o_Phase(phase), .o_Busy(busy)
    );

    bullet_fire_scheduler #(
        .TICK_DIV(4), .PHASE_TICKS(4), .N_ENEMY(15), .PLAYER_COOLDOWN(2)
    ) dut_t (
        .i_Clk(clk), .i_Rst(rst_n), .i_fPlayerShoot(1'b0), .i_PlayerAlive(1'b1),
        .i_EnemyAlive(15'h0000), .i_SpawnReady(1'b1), .o_SpawnValid(t_valid),
        .o_SpawnIsPlayer(t_is_p), .o_SpawnEnemyIdx(t_idx), .o_fTick(t_ftick),
        .o_fPhaseStart(t_pstart), .o_Phase(t_phase), .o_Busy(t_busy)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic p, input logic [3:0] i);
        exp_t e;
        e.is_player = p;
        e.idx = i;
        exp_q.push_back(e);
    endtask

    task automatic wait_pstart(input int limit, output int n);
        n = 0;
        while (!pstart && n < limit) begin
            cyc(1);
            n++;
        end
        chk("pstart_seen", pstart, 1);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            cyc(1);
            n++;
        end
        chk(name, busy, 0);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // Handshake monitor: sampled mid-cycle, a valid&ready pair here transfers at the next edge.
    logic       stall_prev = 1'b0;
    logic [4:0] prev_payload = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", valid, 1);
                chk("stall_payload", {is_p, idx}, prev_payload);
            end
            if (valid && ready) begin
                hs_count++;
                $display("HS %0d player=%0d idx=%0d t=%0t", hs_count, is_p, idx, $time);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_hs actual=player%0d/idx%0d required=none", is_p, idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("hs_is_player", is_p, e.is_player);
                    chk("hs_idx", idx, e.idx);
                end
            end
            stall_prev = valid && !ready;
            prev_payload = {is_p, idx};
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, cur, hs_before;

        tv[0]  = '{0,  1'b0, 1'b0, 2'd0};
        tv[1]  = '{3,  1'b1, 1'b0, 2'd0};
        tv[2]  = '{4,  1'b0, 1'b0, 2'd0};
        tv[3]  = '{7,  1'b1, 1'b0, 2'd0};
        tv[4]  = '{15, 1'b1, 1'b1, 2'd0};
        tv[5]  = '{16, 1'b0, 1'b0, 2'd1};
        tv[6]  = '{19, 1'b1, 1'b0, 2'd1};
        tv[7]  = '{31, 1'b1, 1'b1, 2'd1};
        tv[8]  = '{32, 1'b0, 1'b0, 2'd2};
        tv[9]  = '{47, 1'b1, 1'b1, 2'd2};
        tv[10] = '{48, 1'b0, 1'b0, 2'd3};
        tv[11] = '{63, 1'b1, 1'b1, 2'd3};
        tv[12] = '{64, 1'b0, 1'b0, 2'd0};
        tv[13] = '{79, 1'b1, 1'b1, 2'd0};

        // Reset state
        cyc(3);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", ftick, 0);
        chk("rst_phase", phase, 0);
        chk("rst_t_pstart", t_pstart, 0);
        rst_n = 1'b1;

        // Tick/phase timing table (cycle 0 = first cycle after release)
        cur = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(tv[i].c - cur);
            cur = tv[i].c;
            chk($sformatf("tick_c%0d", tv[i].c), t_ftick, tv[i].tick);
            chk($sformatf("pstart_c%0d", tv[i].c), t_pstart, tv[i].pstart);
            chk($sformatf("phase_c%0d", tv[i].c), t_phase, tv[i].phase);
            chk($sformatf("t_valid_c%0d", tv[i].c), t_valid, 0);
        end
        wait_idle("post_table_idle", 40);

        // All enemies alive, ready high
        e_alive = 15'h7FFF;
        ready = 1'b1;
        for (int i = 0; i < 15; i++) push(1'b0, 4'(i));
        hs_before = hs_count;
        wait_pstart(200, n);
        for (int k = 1; k <= 31; k++) begin
            cyc(1);
            if (k == 30) chk("full_busy_30", busy, 1);
            if (k == 31) chk("full_idle_31", busy, 0);
        end
        e_alive = '0;
        chk("full_hs_count", hs_count - hs_before, 15);
        chk("full_sb_empty", exp_q.size(), 0);

        // Sparse mask with a 5-cycle stall on the first command
        e_alive = 15'h0005;
        ready = 1'b0;
        push(1'b0, 4'd0);
        push(1'b0, 4'd2);
        wait_pstart(200, n);
        n = 0;
        while (!valid && n < 10) begin
            cyc(1);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("stall_hold_valid", valid, 1);
            chk("stall_hold_idx", idx, 0);
            cyc(1);
        end
        ready = 1'b1;
        wait_idle("sparse_idle", 40);
        e_alive = '0;

        // Player shot inserted after the idx 3 transfer
        e_alive = 15'h7FFF;
        for (int i = 0; i < 4; i++) push(1'b0, 4'(i));
        push(1'b1, 4'd0);
        for (int i = 4; i < 15; i++) push(1'b0, 4'(i));
        wait_pstart(200, n);
        cyc(8);
        shoot = 1'b1;
        cyc(2);
        shoot = 1'b0;
        wait_idle("player_mid_idle", 60);
        e_alive = '0;

        // Cooldown: edge one tick after acceptance dropped, after two ticks accepted
        cyc(16);
        shoot = 1'b1;
        push(1'b1, 4'd0);
        n = 0;
        while (!(valid && ready) && n < 20) begin
            cyc(1);
            n++;
        end
        chk("cd_first_valid", valid, 1);
        shoot = 1'b0;
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!ftick && n < 10);
        chk("cd_tick_seen", ftick, 1);
        cyc(1);
        shoot = 1'b1;
        hs_before = hs_count;
        cyc(6);
        chk("cd_drop", hs_count, hs_before);
        shoot = 1'b0;
        cyc(1);
        shoot = 1'b1;
        push(1'b1, 4'd0);
        n = 0;
        while (hs_count == hs_before && n < 20) begin
            cyc(1);
            n++;
        end
        chk("cd_accept", hs_count, hs_before + 1);
        shoot = 1'b0;

        // Dead player cannot fire
        cyc(16);
        p_alive = 1'b0;
        shoot = 1'b1;
        hs_before = hs_count;
        cyc(6);
        chk("dead_player_drop", hs_count, hs_before);
        shoot = 1'b0;
        p_alive = 1'b1;
        wait_idle("dead_idle", 40);

        // Asynchronous reset in the middle of an enemy handshake
        e_alive = 15'h0010;
        ready = 1'b0;
        push(1'b0, 4'd4);
        wait_pstart(200, n);
        n = 0;
        while (!valid && n < 20) begin
            cyc(1);
            n++;
        end
        chk("pre_rst_idx", idx, 4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_idx", idx, 0);
        chk("arst_phase", phase, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        hs_before = hs_count;
        wait_pstart(200, n);
        chk("post_rst_pstart_cycle", n, 63);
        chk("post_rst_no_spawn", hs_count, hs_before);
        push(1'b0, 4'd4);
        cyc(1);
        wait_idle("post_rst_idle", 40);
        chk("post_rst_hs", hs_count, hs_before + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
